// File: rtl/imem_loader.sv
// Boot loader: turns a framed byte stream into little-endian instruction-memory writes.
// The core is held in reset until a complete image with a matching checksum has been loaded.
module imem_loader #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [7:0]  MAGIC       = 8'hA5
) (
  input  logic        CLK,
  input  logic        Rst,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  input  logic        start,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        core_rst_n,
  output logic        load_done,
  output logic        load_err
);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN0, S_LEN1, S_DATA, S_CSUM, S_DONE, S_ERR
  } state_t;

  localparam logic [16:0] DEPTH_LIM = 17'(DEPTH_WORDS);

  state_t      state, state_next;
  logic [7:0]  len_lo;
  logic [15:0] n_words;
  logic [15:0] word_index;
  logic [1:0]  byte_cnt;
  logic [7:0]  csum;
  logic [23:0] word_buf;
  logic [15:0] len_full;
  logic        fire;
  logic        do_write;

  assign byte_ready = (state != S_DONE) && (state != S_ERR);
  assign fire       = byte_valid && byte_ready;
  assign len_full   = {byte_data, len_lo};

  always_comb begin
    state_next = state;
    do_write   = 1'b0;
    // start wins over a simultaneous handshake; that byte is simply dropped
    if (start) begin
      state_next = S_IDLE;
    end else if (fire) begin
      case (state)
        S_IDLE: if (byte_data == MAGIC) state_next = S_LEN0;
        S_LEN0: state_next = S_LEN1;
        S_LEN1: begin
          if ({1'b0, len_full} > DEPTH_LIM) state_next = S_ERR;
          else if (len_full == '0)          state_next = S_CSUM;
          else                              state_next = S_DATA;
        end
        S_DATA: begin
          if (byte_cnt == 2'd3) begin
            do_write = 1'b1;
            if (word_index + 16'd1 == n_words) state_next = S_CSUM;
          end
        end
        S_CSUM: state_next = (byte_data == csum) ? S_DONE : S_ERR;
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge Rst) begin
    if (!Rst) begin
      state      <= S_IDLE;
      len_lo     <= '0;
      n_words    <= '0;
      word_index <= '0;
      byte_cnt   <= '0;
      csum       <= '0;
      word_buf   <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      core_rst_n <= 1'b0;
      load_done  <= 1'b0;
      load_err   <= 1'b0;
    end else begin
      state      <= state_next;
      imem_we    <= do_write;
      core_rst_n <= (state_next == S_DONE);
      load_done  <= (state_next == S_DONE);
      load_err   <= (state_next == S_ERR);
      if (start) begin
        word_index <= '0;
        byte_cnt   <= '0;
        csum       <= '0;
      end else if (fire) begin
        case (state)
          S_LEN0: len_lo  <= byte_data;
          S_LEN1: n_words <= len_full;
          S_DATA: begin
            csum     <= csum ^ byte_data;
            byte_cnt <= byte_cnt + 2'd1;
            case (byte_cnt)
              2'd0: word_buf[7:0]   <= byte_data;
              2'd1: word_buf[15:8]  <= byte_data;
              2'd2: word_buf[23:16] <= byte_data;
              default: ;
            endcase
            if (do_write) begin
              imem_addr  <= {14'b0, word_index, 2'b00};
              imem_wdata <= {byte_data, word_buf};
              word_index <= word_index + 16'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: stimulus pushes expected writes, a monitor pops them on imem_we.
module tb_imem_loader;

  localparam int unsigned DEPTH = 8;
  localparam logic [7:0]  MAGIC = 8'hA5;

  logic        CLK = 1'b0;
  logic        Rst = 1'b1;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_data = '0;
  logic        start = 1'b0;
  logic        byte_ready;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;
  logic        core_rst_n;
  logic        load_done;
  logic        load_err;

  imem_loader #(.DEPTH_WORDS(DEPTH), .MAGIC(MAGIC)) dut (
    .CLK(CLK), .Rst(Rst), .byte_valid(byte_valid), .byte_data(byte_data),
    .byte_ready(byte_ready), .start(start), .imem_we(imem_we),
    .imem_addr(imem_addr), .imem_wdata(imem_wdata), .core_rst_n(core_rst_n),
    .load_done(load_done), .load_err(load_err)
  );

  always #5 CLK = ~CLK;

  typedef struct packed { logic [31:0] addr; logic [31:0] data; } wr_t;

  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  wr_t         exp_q[$];
  int          we_cyc[$];
  logic [31:0] img[0:3];

  always @(posedge CLK) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Monitor: every write pulse must match the oldest expected write
  always @(negedge CLK) begin
    if (Rst && imem_we) begin
      we_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write actual=%h/%h required=none", imem_addr, imem_wdata);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("write_addr", imem_addr, e.addr);
        chk("write_data", imem_wdata, e.data);
      end
    end
  end

  task automatic send(input logic [7:0] b, input bit with_start = 1'b0);
    chk("byte_ready", {31'b0, byte_ready}, 32'd1);
    byte_valid = 1'b1;
    byte_data  = b;
    start      = with_start;
    @(negedge CLK);
    byte_valid = 1'b0;
    start      = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
  endtask

  task automatic load_image(input int n, input bit bad, input int gapmax);
    logic [7:0]  cs;
    logic [31:0] w;
    cs = '0;
    send(MAGIC);
    send(n[7:0]);
    send(n[15:8]);
    for (int i = 0; i < n; i++) begin
      w = img[i];
      exp_q.push_back('{addr: 32'(i * 4), data: w});
      for (int k = 0; k < 4; k++) begin
        send(w[8*k +: 8]);
        cs = cs ^ w[8*k +: 8];
        if (gapmax > 0) repeat ($urandom_range(gapmax, 0)) @(negedge CLK);
      end
    end
    send(bad ? (cs ^ 8'h01) : cs);
  endtask

  task automatic chk_status(input string tag, input logic rdy, input logic crn,
                            input logic done, input logic err);
    chk({tag, "_byte_ready"}, {31'b0, byte_ready}, {31'b0, rdy});
    chk({tag, "_core_rst_n"}, {31'b0, core_rst_n}, {31'b0, crn});
    chk({tag, "_load_done"},  {31'b0, load_done},  {31'b0, done});
    chk({tag, "_load_err"},   {31'b0, load_err},   {31'b0, err});
  endtask

  task automatic chk_reset_vals(input string tag);
    chk_status(tag, 1'b1, 1'b0, 1'b0, 1'b0);
    chk({tag, "_imem_we"},    {31'b0, imem_we}, 32'd0);
    chk({tag, "_imem_addr"},  imem_addr, 32'd0);
    chk({tag, "_imem_wdata"}, imem_wdata, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    img[0] = 32'h0000_0013;
    img[1] = 32'h0010_0093;
    img[2] = 32'hDEAD_BEEF;
    img[3] = 32'h1234_5678;

    #1 Rst = 1'b0;
    repeat (3) @(negedge CLK);
    chk_reset_vals("reset");
    Rst = 1'b1;
    @(negedge CLK);

    // Junk bytes, then the 2-word image (checksum 13^93^10 = 0x90), back-to-back
    send(8'h00); send(8'hFF); send(8'h5A);
    we_cyc.delete();
    load_image(2, 1'b0, 0);
    chk_status("valid", 1'b0, 1'b1, 1'b1, 1'b0);
    chk("we_count", we_cyc.size(), 32'd2);
    if (we_cyc.size() == 2) chk("we_gap", we_cyc[1] - we_cyc[0], 32'd4);
    pulse_start();
    chk_status("restart", 1'b1, 1'b0, 1'b0, 1'b0);

    // Bad checksum: both writes still happen
    load_image(2, 1'b1, 0);
    chk_status("badcsum", 1'b0, 1'b0, 1'b0, 1'b1);
    pulse_start();
    chk_status("errclr", 1'b1, 1'b0, 1'b0, 1'b0);

    // Oversized length: error straight after LEN_HI, no writes
    send(MAGIC); send(8'(DEPTH + 1)); send(8'h00);
    chk_status("toolong", 1'b0, 1'b0, 1'b0, 1'b1);
    repeat (4) @(negedge CLK);
    pulse_start();

    // Zero-length image
    send(MAGIC); send(8'h00); send(8'h00); send(8'h00);
    chk_status("zerolen", 1'b0, 1'b1, 1'b1, 1'b0);
    pulse_start();

    // Random gaps inside words
    load_image(3, 1'b0, 3);
    chk_status("gaps", 1'b0, 1'b1, 1'b1, 1'b0);
    pulse_start();

    // Abort on the 3rd byte of the second word: only word 0 written
    send(MAGIC); send(8'h03); send(8'h00);
    exp_q.push_back('{addr: 32'd0, data: img[0]});
    for (int k = 0; k < 4; k++) send(img[0][8*k +: 8]);
    send(img[1][7:0]); send(img[1][15:8]);
    send(img[1][23:16], 1'b1);
    repeat (4) @(negedge CLK);
    chk_status("abort", 1'b1, 1'b0, 1'b0, 1'b0);
    load_image(2, 1'b0, 0);
    chk_status("afterabort", 1'b0, 1'b1, 1'b1, 1'b0);
    pulse_start();

    // Asynchronous reset during DATA, after two writes
    send(MAGIC); send(8'h03); send(8'h00);
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back('{addr: 32'(i * 4), data: img[i]});
      for (int k = 0; k < 4; k++) send(img[i][8*k +: 8]);
    end
    send(img[2][7:0]);
    #2 Rst = 1'b0;
    #1 chk_reset_vals("midreset");
    @(negedge CLK);
    Rst = 1'b1;
    @(negedge CLK);
    load_image(3, 1'b0, 0);
    chk_status("afterreset", 1'b0, 1'b1, 1'b1, 1'b0);

    repeat (4) @(negedge CLK);
    chk("pending_writes", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
